// File: rtl/pipe_set_en_if.sv
// Handshake bundle for pipe_set_en: upstream valid/ready/data, downstream valid/ready/data
// and the occupancy count. The pipeline uses the slave modport.
interface pipe_set_en_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipe_set_en.sv
// Elastic DEPTH-stage register slice with bubble collapsing, global enable and
// synchronous flush of every stage to SET_VAL.
module pipe_set_en #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 3,
  parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{1'b1}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         set_i,
  input  logic         en_i,
  pipe_set_en_if.slave bus
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [WIDTH-1:0] dat_q [DEPTH];
  logic [WIDTH-1:0] dat_d [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic [DEPTH:0]   src_vld;
  logic [WIDTH-1:0] src_dat [DEPTH+1];
  logic [OCC_W-1:0] occ;
  logic             xfer_ok;

  // rst_n gates the handshake so nothing looks ready while reset is asserted.
  assign xfer_ok = rst_n & en_i & ~set_i;

  // rdy[i] is true when any stage from i to the output is empty or the sink is taking a word.
  always_comb begin
    logic run;
    run = bus.out_ready;
    rdy = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      run    = run | ~vld_q[i];
      rdy[i] = run;
    end
  end

  always_comb begin
    src_vld    = {vld_q, bus.in_valid};
    src_dat[0] = bus.in_data;
    for (int i = 0; i < DEPTH; i++) begin
      src_dat[i+1] = dat_q[i];
    end
  end

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (set_i) begin
      vld_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat_d[i] = SET_VAL;
      end
    end else if (en_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i]) begin
          vld_d[i] = src_vld[i];
          if (src_vld[i]) begin
            dat_d[i] = src_dat[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= SET_VAL;
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= dat_d[i];
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ = occ + OCC_W'(vld_q[i]);
    end
  end

  assign bus.in_ready  = xfer_ok & rdy[0];
  assign bus.out_valid = xfer_ok & vld_q[DEPTH-1];
  assign bus.out_data  = dat_q[DEPTH-1];
  assign bus.occupancy = occ;

endmodule

// File: tb/tb_pipe_set_en.sv
// Self-checking bench for pipe_set_en (WIDTH=8, DEPTH=3) with directed scenarios and a
// randomized run against a word-queue reference model.
module tb_pipe_set_en;
  localparam int W     = 8;
  localparam int D     = 3;
  localparam int OCC_W = $clog2(D + 1);

  logic clk;
  logic rst_n;
  logic set_r;
  logic en_r;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: words in acceptance order, each with the number of enabled edges
  // it has spent inside. The oldest word is visible once it has aged DEPTH-1 edges.
  logic [W-1:0] q_dat[$];
  int           q_age[$];

  pipe_set_en_if #(.WIDTH(W), .DEPTH(D)) bus ();

  pipe_set_en #(.WIDTH(W), .DEPTH(D), .SET_VAL(8'hFF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .set_i (set_r),
    .en_i  (en_r),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit m_in_ready();
    return rst_n && en_r && !set_r && ((q_dat.size() < D) || bus.out_ready);
  endfunction

  function automatic bit m_out_valid();
    return rst_n && en_r && !set_r && (q_dat.size() > 0) && (q_age[0] >= D - 1);
  endfunction

  task automatic m_clear();
    q_dat.delete();
    q_age.delete();
  endtask

  task automatic tick();
    bit ia, oa;
    ia = bus.in_valid && m_in_ready();
    oa = m_out_valid() && bus.out_ready;
    @(posedge clk);
    if (!rst_n || set_r) begin
      m_clear();
    end else if (en_r) begin
      if (oa) begin
        void'(q_dat.pop_front());
        void'(q_age.pop_front());
      end
      foreach (q_age[k]) q_age[k]++;
      if (ia) begin
        q_dat.push_back(bus.in_data);
        q_age.push_back(0);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; set_r = 1'b0; en_r = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    m_clear();
    repeat (2) @(posedge clk);
    #2;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    n_checks++; if (bus.occupancy !== OCC_W'(0)) begin n_errors++; $display("FAIL reset_occupancy: got %0d expected 0", bus.occupancy); end
    n_checks++; if (bus.out_data !== 8'hFF) begin n_errors++; $display("FAIL reset_out_data: got %h expected ff", bus.out_data); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL release_in_ready: got %b expected 1", bus.in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_streaming();
    logic [W-1:0] got[$];
    int first = -1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bus.in_valid = (c < 8);
      bus.in_data  = W'(c + 1);
      #2;
      if (c < 8) begin
        n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL stream_in_ready c=%0d: got %b expected 1", c, bus.in_ready); end
      end
      if (c == 5) begin
        n_checks++; if (bus.occupancy !== OCC_W'(D)) begin n_errors++; $display("FAIL stream_occupancy: got %0d expected %0d", bus.occupancy, D); end
      end
      if (bus.out_valid) begin
        if (first < 0) first = c;
        got.push_back(bus.out_data);
      end
      tick();
    end
    n_checks++; if (first != D) begin n_errors++; $display("FAIL stream_latency: got %0d expected %0d", first, D); end
    n_checks++; if (got.size() != 8) begin n_errors++; $display("FAIL stream_count: got %0d expected 8", got.size()); end
    foreach (got[k]) begin
      n_checks++; if (got[k] !== W'(k + 1)) begin n_errors++; $display("FAIL stream_data[%0d]: got %h expected %h", k, got[k], W'(k + 1)); end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] vals[4] = '{8'h10, 8'h11, 8'h12, 8'h13};
    logic [W-1:0] exp_out[4] = '{8'h10, 8'h11, 8'h12, 8'h13};
    logic [W-1:0] got[$];
    int idx = 0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = vals[idx];
      #2;
      if (c == 3) begin
        n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_full_in_ready: got %b expected 0", bus.in_ready); end
        n_checks++; if (bus.occupancy !== OCC_W'(D)) begin n_errors++; $display("FAIL bp_occupancy: got %0d expected %0d", bus.occupancy, D); end
      end
      if (bus.in_ready) idx++;
      tick();
    end
    n_checks++; if (idx != 3) begin n_errors++; $display("FAIL bp_accepted: got %0d expected 3", idx); end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = vals[idx < 4 ? idx : 3];
    #2;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_passthru_in_ready: got %b expected 1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h10) begin n_errors++; $display("FAIL bp_first_out: got v=%b d=%h expected v=1 d=10", bus.out_valid, bus.out_data); end
    if (bus.out_valid) got.push_back(bus.out_data);
    tick();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #2;
      if (bus.out_valid) got.push_back(bus.out_data);
      tick();
    end
    n_checks++; if (got.size() != 4) begin n_errors++; $display("FAIL bp_count: got %0d expected 4", got.size()); end
    foreach (got[k]) begin
      if (k < 4) begin
        n_checks++; if (got[k] !== exp_out[k]) begin n_errors++; $display("FAIL bp_data[%0d]: got %h expected %h", k, got[k], exp_out[k]); end
      end
    end
  endtask

  task automatic test_bubble();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'hA0; tick();
    bus.in_valid = 1'b0; tick();
    bus.in_valid = 1'b1; bus.in_data = 8'hA1; tick();
    bus.in_valid = 1'b0; tick();
    tick();
    #2;
    n_checks++; if (bus.occupancy !== OCC_W'(2)) begin n_errors++; $display("FAIL bubble_occupancy: got %0d expected 2", bus.occupancy); end
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA0) begin n_errors++; $display("FAIL bubble_head: got v=%b d=%h expected v=1 d=a0", bus.out_valid, bus.out_data); end
    bus.out_ready = 1'b1;
    #1;
    tick();
    #2;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA1) begin n_errors++; $display("FAIL bubble_second: got v=%b d=%h expected v=1 d=a1", bus.out_valid, bus.out_data); end
    tick();
    #2;
    n_checks++; if (bus.occupancy !== OCC_W'(0)) begin n_errors++; $display("FAIL bubble_drained: got %0d expected 0", bus.occupancy); end
  endtask

  task automatic test_enable_freeze();
    logic [W-1:0] got[$];
    int nxt = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      en_r         = !(c >= 4 && c < 8);
      bus.in_valid = (nxt < 6);
      bus.in_data  = W'(8'h30 + nxt);
      #2;
      if (!en_r) begin
        n_checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL freeze_handshake c=%0d: got r=%b v=%b expected 0 0", c, bus.in_ready, bus.out_valid); end
        n_checks++; if (bus.occupancy !== OCC_W'(q_dat.size())) begin n_errors++; $display("FAIL freeze_occupancy c=%0d: got %0d expected %0d", c, bus.occupancy, q_dat.size()); end
      end
      if (bus.in_valid && bus.in_ready) nxt++;
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
      tick();
    end
    en_r = 1'b1;
    n_checks++; if (got.size() != 6) begin n_errors++; $display("FAIL freeze_count: got %0d expected 6", got.size()); end
    foreach (got[k]) begin
      n_checks++; if (got[k] !== W'(8'h30 + k)) begin n_errors++; $display("FAIL freeze_data[%0d]: got %h expected %h", k, got[k], W'(8'h30 + k)); end
    end
  endtask

  task automatic test_flush();
    int seen = 0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data = 8'h55; tick();
    bus.in_data = 8'h66; tick();
    bus.in_data = 8'h77; tick();
    en_r = 1'b0; set_r = 1'b1; bus.in_data = 8'h99;
    #2;
    n_checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL flush_gate: got r=%b v=%b expected 0 0", bus.in_ready, bus.out_valid); end
    tick();
    set_r = 1'b0; en_r = 1'b1; bus.in_valid = 1'b0;
    #2;
    n_checks++; if (bus.occupancy !== OCC_W'(0)) begin n_errors++; $display("FAIL flush_occupancy: got %0d expected 0", bus.occupancy); end
    n_checks++; if (bus.out_data !== 8'hFF) begin n_errors++; $display("FAIL flush_out_data: got %h expected ff", bus.out_data); end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (bus.out_valid) seen++;
      tick();
    end
    n_checks++; if (seen != 0) begin n_errors++; $display("FAIL flush_ghost: got %0d words expected 0", seen); end
    bus.in_valid = 1'b1; bus.in_data = 8'h42; tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    #2;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h42) begin n_errors++; $display("FAIL flush_next_word: got v=%b d=%h expected v=1 d=42", bus.out_valid, bus.out_data); end
    tick();
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data = 8'hC1; tick();
    bus.in_data = 8'hC2; tick();
    bus.in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    m_clear();
    #1;
    n_checks++; if (bus.occupancy !== OCC_W'(0)) begin n_errors++; $display("FAIL arst_occupancy: got %0d expected 0", bus.occupancy); end
    n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL arst_handshake: got v=%b r=%b expected 0 0", bus.out_valid, bus.in_ready); end
    n_checks++; if (bus.out_data !== 8'hFF) begin n_errors++; $display("FAIL arst_out_data: got %h expected ff", bus.out_data); end
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      en_r          = ($urandom_range(7) != 0);
      set_r         = ($urandom_range(29) == 0);
      bus.in_valid  = ($urandom_range(9) < 7);
      bus.out_ready = ($urandom_range(9) < 6);
      bus.in_data   = W'($urandom);
      #2;
      n_checks++; if (bus.in_ready !== m_in_ready()) begin n_errors++; $display("FAIL rand_in_ready c=%0d: got %b expected %b", c, bus.in_ready, m_in_ready()); end
      n_checks++; if (bus.out_valid !== m_out_valid()) begin n_errors++; $display("FAIL rand_out_valid c=%0d: got %b expected %b", c, bus.out_valid, m_out_valid()); end
      n_checks++; if (bus.occupancy !== OCC_W'(q_dat.size())) begin n_errors++; $display("FAIL rand_occupancy c=%0d: got %0d expected %0d", c, bus.occupancy, q_dat.size()); end
      if (m_out_valid()) begin
        n_checks++; if (bus.out_data !== q_dat[0]) begin n_errors++; $display("FAIL rand_out_data c=%0d: got %h expected %h", c, bus.out_data, q_dat[0]); end
      end
      tick();
    end
    set_r = 1'b0;
    en_r  = 1'b1;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_enable_freeze();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary line");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_set_en.md
Name: pipe_set_en

Overview:
Parametrised elastic register pipeline built from settable, enabled flops. It carries WIDTH-bit data through DEPTH stages under a valid/ready handshake, with bubble collapsing, a global clock enable and a synchronous flush-to-SET_VAL. It is used as a retiming/buffering slice between datapath blocks and stores up to DEPTH words.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 3, number of register stages (>=1); also the buffer capacity
SET_VAL, {WIDTH{1'b1}}, data value loaded into every stage on reset or set

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous reset, active-low
set  input  1  synchronous flush, active-high
en  input  1  global enable; 0 freezes all state
in_valid  input  1  upstream word valid
in_ready  output  1  pipeline accepts in_data this cycle
in_data  input  WIDTH  upstream data
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data
out_data  output  WIDTH  data of last stage
occupancy  output  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH

Behaviour:
- State per stage i (0..DEPTH-1): vld[i] and dat[i]. Stage DEPTH-1 drives the outputs.
- Priority is rst_n > set > en.
- Reset (rst_n=0, asynchronous): all vld=0 and all dat=SET_VAL. Outputs during reset: out_valid=0, in_ready=0, occupancy=0, out_data=SET_VAL.
- set=1 at a clock edge: all vld<=0 and all dat<=SET_VAL, independent of en, in_valid and out_ready. No transfer occurs in a cycle with set=1: in_ready=0 and out_valid=0, combinationally gated.
- en=0 with set=0: every register holds, in_ready=0 and out_valid=0. No handshake can complete. occupancy still reports the held count.
- Ready chain (combinational):
  - rdy[DEPTH] = out_ready.
  - rdy[i] = ~vld[i] | rdy[i+1].
  - in_ready = en & ~set & rdy[0].
  - out_valid = en & ~set & vld[DEPTH-1].
  - out_data = dat[DEPTH-1].
- Stage update when en=1, set=0 and rdy[i]=1:
  - vld[i] <= src_vld, where src_vld is vld[i-1] for i>0 and in_valid for i=0.
  - dat[i] <= src_dat only when src_vld=1; otherwise dat[i] holds.
- Stage hold: if rdy[i]=0, stage i holds both vld and dat.
- Transfers:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - Simultaneous input and output transfer in one cycle is allowed.
- Latency: a word accepted at edge N with no stalls appears on out_valid after DEPTH edges (first visible in the cycle after edge N+DEPTH-1). Throughput is 1 word/cycle.
- Bubble collapse: an empty stage accepts from its predecessor even when downstream is stalled. With out_ready=0 the pipeline fills to DEPTH words, then in_ready=0.
- Full (occupancy=DEPTH) with out_ready=1: in_ready=1, enabling a same-cycle pass-through and full throughput.
- Empty: out_valid=0. out_data shows the last held data or SET_VAL; it is don't-care for consumers.
- Ordering: words exit in acceptance order. No loss, no duplication.
- Words exiting: data of dropped words is never observed after set.
- occupancy: combinational popcount of vld; width $clog2(DEPTH+1). For DEPTH=1 the width is 1.
- The in_valid-must-hold-until-in_ready rule is an upstream protocol requirement and is not checked.
- DEPTH=1 degenerates to a single-entry register with combinational in_ready = ~vld | out_ready.

Test Plan:
1. Reset/idle (WIDTH=8, DEPTH=3): hold rst_n=0 -> out_valid=0, in_ready=0, occupancy=0, out_data=8'hFF. Release rst_n with en=1 -> in_ready=1.
2. Streaming: in_valid=1 with data 0x01..0x08 on consecutive cycles, out_ready=1 -> first out_valid 3 edges after first accept. Outputs 0x01..0x08 back-to-back. occupancy steady at 3.
3. Backpressure: out_ready=0, offer 0x10,0x11,0x12,0x13 -> 3 accepted, in_ready=0 on 4th, occupancy=3. Raise out_ready -> 0x10,0x11,0x12 emitted in order, 0x13 accepted the same cycle 0x10 leaves.
4. Bubble collapse: load 0xA0, idle one cycle, load 0xA1 with out_ready=0 -> both land in stages 2,1 adjacently, occupancy=2. Release -> 0xA0 then 0xA1 on consecutive cycles.
5. Enable freeze: mid-stream drop en for 4 cycles -> in_ready=0, out_valid=0, all state and occupancy unchanged. Restore en -> stream resumes with no loss or duplication.
6. Flush: fill with 0x55,0x66,0x77, pulse set=1 for one cycle with en=0 and in_valid=1 -> next cycle occupancy=0, all dat=0xFF, the offered word is not accepted. An async rst_n pulse mid-stream gives the same result immediately, without a clock edge.
